// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - minimal TL-UL request/response types and opcodes
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/student_tlul_sample_fifo.sv
// rtl/student_tlul_sample_fifo.sv - TL-UL sample FIFO feeding the FIR stream
// Optional error responses are enabled by defining STUDENT_SAMPLE_FIFO_ERR_EN.
module student_tlul_sample_fifo #(
  parameter int  DEPTH    = 16,
  parameter int  SAMPLE_W = 16,
  localparam int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  tlul_pkg::tl_h2d_t   tl_i,
  output tlul_pkg::tl_d2h_t   tl_o,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_valid_o,
  input  logic                sample_ready_i,
  output logic                irq_o
);

  localparam int AW = $clog2(DEPTH);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [LVL_W-1:0]    wptr, rptr, level, thresh;
  logic                overflow, full, empty;

  logic                d_valid, d_error;
  logic [2:0]          d_opcode;
  logic [1:0]          d_size;
  logic [7:0]          d_source;
  logic [31:0]         d_data;

  logic [5:0]          addr;
  logic                accept, is_get, mask_ok, mapped, err, wr_ok;
  logic                push_req, push_do, pop, ctrl_we, flush, clr_ovf, set_ovf, thresh_we;
  logic [31:0]         status, rdata;

  assign addr    = tl_i.a_address[5:0];
  assign accept  = tl_i.a_valid && !d_valid;
  assign is_get  = (tl_i.a_opcode == tlul_pkg::Get);
  assign mask_ok = (tl_i.a_mask == 4'hF);
  assign mapped  = (addr[1:0] == 2'b00) && (addr[5:4] == 2'b00);

`ifdef STUDENT_SAMPLE_FIFO_ERR_EN
  assign err = !mapped || (!is_get && (!mask_ok || addr == 6'h04)) || (tl_i.a_size != 2'd2);
`else
  assign err = 1'b0;
`endif

  assign wr_ok     = accept && !is_get && mask_ok && !err;
  assign push_req  = wr_ok && (addr == 6'h00);
  assign ctrl_we   = wr_ok && (addr == 6'h08);
  assign flush     = ctrl_we && tl_i.a_data[0];
  assign clr_ovf   = ctrl_we && tl_i.a_data[1];
  assign thresh_we = wr_ok && (addr == 6'h0C);

  assign level = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[LVL_W-1] != rptr[LVL_W-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop frees the slot at this edge, so a push into a full FIFO still lands.
  assign pop     = !empty && sample_ready_i;
  assign push_do = push_req && (!full || pop);
  assign set_ovf = push_req && full && !pop;

  assign sample_o       = mem[rptr[AW-1:0]];
  assign sample_valid_o = !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_do) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_do) mem[wptr[AW-1:0]] <= tl_i.a_data[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow <= 1'b0;
      thresh   <= '0;
      irq_o    <= 1'b0;
    end else begin
      if (clr_ovf)      overflow <= 1'b0;
      else if (set_ovf) overflow <= 1'b1;
      if (thresh_we)    thresh   <= tl_i.a_data[LVL_W-1:0];
      irq_o <= (thresh != '0) && (level >= thresh);
    end
  end

  always_comb begin
    status             = '0;
    status[LVL_W-1:0]  = level;
    status[16]         = empty;
    status[17]         = full;
    status[18]         = overflow;
  end

  always_comb begin
    rdata = '0;
    if (is_get && !err) begin
      case (addr)
        6'h00:   rdata[SAMPLE_W-1:0] = sample_o;
        6'h04:   rdata = status;
        6'h0C:   rdata[LVL_W-1:0] = thresh;
        default: rdata = '0;
      endcase
    end
  end

  // Response fields are captured at accept and held until the host takes them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_valid  <= 1'b0;
      d_opcode <= 3'h0;
      d_size   <= 2'h0;
      d_source <= 8'h0;
      d_data   <= 32'h0;
      d_error  <= 1'b0;
    end else if (accept) begin
      d_valid  <= 1'b1;
      d_opcode <= is_get ? tlul_pkg::AccessAckData : tlul_pkg::AccessAck;
      d_size   <= tl_i.a_size;
      d_source <= tl_i.a_source;
      d_data   <= rdata;
      d_error  <= err;
    end else if (d_valid && tl_i.d_ready) begin
      d_valid  <= 1'b0;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = d_opcode;
    tl_o.d_size   = d_size;
    tl_o.d_source = d_source;
    tl_o.d_data   = d_data;
    tl_o.d_error  = d_error;
    tl_o.a_ready  = !d_valid;
  end

  logic unused_bits;
  assign unused_bits = ^{tl_i.a_param, tl_i.a_address[31:6], tl_i.a_data[31:SAMPLE_W]};

endmodule

// File: tb/tb_student_tlul_sample_fifo.sv
// tb/tb_student_tlul_sample_fifo.sv - randomized bench with queue-based FIFO model
module tb_student_tlul_sample_fifo;

  logic               clk = 1'b0;
  logic               rst_n;
  tlul_pkg::tl_h2d_t  tl_i;
  tlul_pkg::tl_d2h_t  tl_o;
  logic [15:0]        sample;
  logic               sample_valid;
  logic               sample_ready;
  logic               irq;

  always #5 clk = ~clk;

  student_tlul_sample_fifo dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tl_i           (tl_i),
    .tl_o           (tl_o),
    .sample_o       (sample),
    .sample_valid_o (sample_valid),
    .sample_ready_i (sample_ready),
    .irq_o          (irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of samples plus overflow, threshold and irq bits.
  logic [15:0] q[$];
  bit          m_ovf;
  int          m_thresh;
  bit          m_irq;
  logic [31:0] exp_rdata;
  bit          exp_rchk;
  bit          exp_err;

  function automatic bit is_err(bit wr, logic [5:0] a, logic [3:0] m, logic [1:0] s);
`ifdef STUDENT_SAMPLE_FIFO_ERR_EN
    return (a[1:0] != 2'b00) || (a[5:4] != 2'b00) || (wr && (m != 4'hF || a == 6'h04)) || (s != 2'd2);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ovf    = 0;
      m_thresh = 0;
      m_irq    = 0;
    end else begin
      bit acc, wr, e, pop, full, push, do_flush, do_clr;
      logic [5:0] a;
      int lvl;
      lvl = q.size();
      chk("sample_valid", {31'b0, sample_valid}, {31'b0, lvl > 0});
      if (lvl > 0) chk("sample_head", {16'b0, sample}, {16'b0, q[0]});
      chk("irq", {31'b0, irq}, {31'b0, m_irq});
      m_irq = (m_thresh != 0) && (lvl >= m_thresh);

      acc  = tl_i.a_valid && tl_o.a_ready;
      wr   = (tl_i.a_opcode != tlul_pkg::Get);
      a    = tl_i.a_address[5:0];
      e    = is_err(wr, a, tl_i.a_mask, tl_i.a_size);
      pop  = (lvl > 0) && sample_ready;
      full = (lvl == 16);
      push = 0; do_flush = 0; do_clr = 0;
      if (acc) begin
        exp_err   = e;
        exp_rchk  = 1;
        exp_rdata = 32'h0;
        if (!wr && !e) begin
          case (a)
            6'h00: if (lvl > 0) exp_rdata = {16'h0, q[0]}; else exp_rchk = 0;
            6'h04: exp_rdata = {13'b0, m_ovf, full, lvl == 0, 11'b0, 5'(lvl)};
            6'h0C: exp_rdata = 32'(m_thresh);
            default: exp_rdata = 32'h0;
          endcase
        end
        if (wr && !e && tl_i.a_mask == 4'hF) begin
          case (a)
            6'h00: push = 1;
            6'h08: begin do_flush = tl_i.a_data[0]; do_clr = tl_i.a_data[1]; end
            6'h0C: m_thresh = int'(tl_i.a_data[4:0]);
            default: ;
          endcase
        end
      end
      if (do_flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          if (!full || pop) q.push_back(tl_i.a_data[15:0]);
          else m_ovf = 1;
        end
      end
      if (do_clr) m_ovf = 0;
    end
  end

  bit rnd_en = 0;
  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      sample_ready = 1'($urandom_range(0, 1));
    end
  end

  logic [31:0] rdv;

  task automatic bus(input bit wr, input logic [5:0] a, input logic [31:0] d, input logic [3:0] m,
                     input logic [1:0] s, input int hold, input bit pulse, output logic [31:0] rd);
    logic [7:0]  src;
    logic [31:0] d0;
    int n;
    src = 8'($urandom);
    rd  = 32'h0;
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = wr ? ((m == 4'hF) ? tlul_pkg::PutFullData : tlul_pkg::PutPartialData) : tlul_pkg::Get;
    tl_i.a_address = {26'h0, a};
    tl_i.a_data    = d;
    tl_i.a_mask    = m;
    tl_i.a_size    = s;
    tl_i.a_source  = src;
    tl_i.d_ready   = (hold == 0);
    if (pulse) sample_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!tl_o.a_ready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) begin
      chk("a_ready_timeout", 32'h0, 32'h1);
      tl_i.a_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    if (pulse) sample_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!tl_o.d_valid && n < 20) begin n++; @(negedge clk); end
    if (n >= 20) begin
      chk("d_valid_timeout", 32'h0, 32'h1);
      tl_i.d_ready = 1'b1;
      return;
    end
    rd = tl_o.d_data;
    chk("d_opcode", {29'b0, tl_o.d_opcode}, {29'b0, wr ? tlul_pkg::AccessAck : tlul_pkg::AccessAckData});
    chk("d_source", {24'b0, tl_o.d_source}, {24'b0, src});
    chk("d_size", {30'b0, tl_o.d_size}, {30'b0, s});
    chk("d_error", {31'b0, tl_o.d_error}, {31'b0, exp_err});
    if (exp_rchk) chk("d_data", rd, exp_rdata);
    if (hold > 0) begin
      d0 = rd;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_d_valid", {31'b0, tl_o.d_valid}, 32'h1);
        chk("hold_d_data", tl_o.d_data, d0);
        chk("hold_a_ready", {31'b0, tl_o.a_ready}, 32'h0);
      end
      @(posedge clk); #1;
      tl_i.d_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk("d_valid_drop", {31'b0, tl_o.d_valid}, 32'h0);
  endtask

  task automatic wr_reg(input logic [5:0] a, input logic [31:0] d);
    bus(1, a, d, 4'hF, 2'd2, 0, 0, rdv);
  endtask

  task automatic rd_reg(input logic [5:0] a);
    bus(0, a, 32'h0, 4'hF, 2'd2, 0, 0, rdv);
  endtask

  task automatic drain();
    sample_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    sample_ready = 1'b0;
    @(negedge clk);
    chk("drained_empty", {31'b0, sample_valid}, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] a;
    logic [3:0] m;
    logic [1:0] s;
    logic [31:0] d;
    bit w;
    tl_i = '0;
    tl_i.d_ready = 1'b1;
    sample_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_a_ready", {31'b0, tl_o.a_ready}, 32'h1);
    chk("rst_d_valid", {31'b0, tl_o.d_valid}, 32'h0);
    chk("rst_sample_valid", {31'b0, sample_valid}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    rd_reg(6'h04);
    chk("rst_status", rdv, 32'h0001_0000);

    wr_reg(6'h00, 32'h11);
    wr_reg(6'h00, 32'h22);
    wr_reg(6'h00, 32'h33);
    rd_reg(6'h04);
    chk("status_lvl3", rdv, 32'h0000_0003);
    rd_reg(6'h00);
    chk("peek_head", rdv, 32'h11);
    chk("sample_head_11", {16'b0, sample}, 32'h11);

    for (int i = 0; i < 13; i++) wr_reg(6'h00, 32'($urandom_range(0, 16'hFFFF)));
    wr_reg(6'h00, 32'h99);
    rd_reg(6'h04);
    chk("status_full_ovf", rdv, 32'h0006_0010);
    drain();
    wr_reg(6'h08, 32'h2);
    rd_reg(6'h04);
    chk("status_ovf_clr", rdv, 32'h0001_0000);

    for (int i = 0; i < 16; i++) wr_reg(6'h00, 32'h100 + 32'(i));
    bus(1, 6'h00, 32'h55, 4'hF, 2'd2, 0, 1, rdv);
    rd_reg(6'h04);
    chk("status_full_pop_push", rdv, 32'h0002_0010);
    drain();

    wr_reg(6'h0C, 32'h4);
    rd_reg(6'h0C);
    chk("thresh_rb", rdv, 32'h4);
    for (int i = 0; i < 3; i++) wr_reg(6'h00, 32'h200 + 32'(i));
    repeat (2) @(negedge clk);
    chk("irq_lvl3", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    wr_reg(6'h00, 32'h203);
    @(negedge clk);
    chk("irq_lvl4", {31'b0, irq}, 32'h1);
    @(posedge clk); #1;
    wr_reg(6'h08, 32'h1);
    @(negedge clk);
    chk("irq_flush", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    rd_reg(6'h04);
    chk("status_flush", rdv, 32'h0001_0000);

    wr_reg(6'h00, 32'hABCD);
    bus(0, 6'h00, 32'h0, 4'hF, 2'd2, 5, 0, rdv);
    chk("hold_get_data", rdv, 32'hABCD);

`ifdef STUDENT_SAMPLE_FIFO_ERR_EN
    rd_reg(6'h3C);
    chk("err_3c_data", rdv, 32'h0);
`endif

    rnd_en = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: a = 6'h00;
        3:       a = 6'h04;
        4:       a = 6'h08;
        5:       a = 6'h0C;
        default: a = 6'($urandom);
      endcase
      w = ($urandom_range(0, 2) != 0);
      m = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
      s = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'd2;
      if (a == 6'h08)      d = ($urandom_range(0, 5) == 0) ? 32'h1 : 32'h2;
      else if (a == 6'h0C) d = 32'($urandom_range(0, 20));
      else                 d = $urandom;
      bus(w, a, d, m, s, 0, 0, rdv);
    end
    rnd_en = 0;
    @(posedge clk); #2;
    sample_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
